// File: rtl/palette_pkg.sv
// Shared types for the palette lookup engine: colour word layout and flash FSM states.
package palette_pkg;

    localparam int COLOR_W = 4;

    typedef struct packed {
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] blue;
    } rgb_t;

    localparam rgb_t WHITE = '1;
    localparam rgb_t BLACK = '0;

    typedef enum logic {
        STEADY   = 1'b0,
        FLASHING = 1'b1
    } flash_state_t;

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port palette store: one synchronous write port, one registered read port.
module palette_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on storage or read data so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/palette_bank_lut.sv
// Runtime-loadable multi-palette index->RGB lookup with transparency key and frame-synced flash.
module palette_bank_lut
    import palette_pkg::*;
#(
    parameter int NUM_PAL      = 32,
    parameter int IDX_W        = 4,
    parameter int COLOR_W      = palette_pkg::COLOR_W,
    parameter int FLASH_FRAMES = 4,
    parameter int TRANSP_IDX   = 0,
    localparam int PSEL_W      = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1,
    localparam int CNT_W       = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 in_valid,
    input  logic [PSEL_W-1:0]    pal_sel,
    input  logic [IDX_W-1:0]     index,
    input  logic                 key_en,
    input  logic                 wr_en,
    input  logic [PSEL_W-1:0]    wr_pal,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [3*COLOR_W-1:0] wr_data,
    input  logic                 flash_en,
    input  logic                 frame_tick,
    output logic                 out_valid,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 out_transp,
    output flash_state_t         flash_state,
    output logic [CNT_W-1:0]     flash_cnt,
    output logic                 flash_phase
);

    localparam int DATA_W = 3 * COLOR_W;
    localparam int ADDR_W = PSEL_W + IDX_W;
    localparam int DEPTH  = NUM_PAL * (2 ** IDX_W);
    localparam logic [PSEL_W:0]  NUM_PAL_V = (PSEL_W + 1)'(NUM_PAL);
    localparam logic [IDX_W-1:0] KEY_IDX   = IDX_W'(TRANSP_IDX);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FLASH_FRAMES - 1);

    // Handshake: in_valid qualifies one request per cycle with no backpressure;
    // exactly one out_valid pulse follows two edges later, in request order.

    logic              wr_ok;
    logic              rd_ok;
    logic              wr_hit;
    logic [DATA_W-1:0] ram_rd_data;

    assign wr_ok  = wr_en && ({1'b0, wr_pal} < NUM_PAL_V);
    assign rd_ok  = ({1'b0, pal_sel} < NUM_PAL_V);
    assign wr_hit = wr_ok && (wr_pal == pal_sel) && (wr_idx == index);

    palette_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (Clk),
        .we    (wr_ok),
        .waddr ({wr_pal, wr_idx}),
        .wdata (wr_data),
        .re    (in_valid),
        .raddr ({pal_sel, index}),
        .rdata (ram_rd_data)
    );

    // Stage 1: side information travelling alongside the registered RAM read.
    logic              s1_valid;
    logic              s1_oor;
    logic              s1_transp;
    logic              s1_byp;
    logic [DATA_W-1:0] s1_byp_data;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid    <= 1'b0;
            s1_oor      <= 1'b0;
            s1_transp   <= 1'b0;
            s1_byp      <= 1'b0;
            s1_byp_data <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_oor      <= !rd_ok;
                s1_transp   <= key_en && (index == KEY_IDX);
                s1_byp      <= wr_hit;
                s1_byp_data <= wr_data;
            end
        end
    end

    // Flash FSM
    flash_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= STEADY;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        case (state_q)
            STEADY: begin
                if (flash_en) begin
                    state_d = FLASHING;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
            end
            FLASHING: begin
                // Dropping flash_en takes priority over a coincident tick.
                if (!flash_en) begin
                    state_d = STEADY;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end else if (frame_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        phase_d = !phase_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = STEADY;
            end
        endcase
    end

    assign flash_state = state_q;
    assign flash_cnt   = cnt_q;
    assign flash_phase = phase_q;

    // Stage 2: range check dominates, then keying, then flash override.
    logic [DATA_W-1:0] res_rgb;
    logic              res_transp;

    always_comb begin
        res_rgb    = '0;
        res_transp = 1'b0;
        if (!s1_oor) begin
            if (s1_transp) begin
                res_transp = 1'b1;
            end else if (phase_q) begin
                res_rgb = '1;
            end else begin
                res_rgb = s1_byp ? s1_byp_data : ram_rd_data;
            end
        end
    end

    logic [DATA_W-1:0] out_rgb;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid  <= 1'b0;
            out_rgb    <= '0;
            out_transp <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_rgb    <= res_rgb;
                out_transp <= res_transp;
            end
        end
    end

    assign red   = out_rgb[3*COLOR_W-1:2*COLOR_W];
    assign green = out_rgb[2*COLOR_W-1:COLOR_W];
    assign blue  = out_rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_palette_bank_lut.sv
// Directed bench for palette_bank_lut: 30 palettes, 2-frame flash half-period.
module tb_palette_bank_lut;
    import palette_pkg::*;

    localparam int NUM_PAL      = 30;
    localparam int IDX_W        = 4;
    localparam int CW           = 4;
    localparam int FLASH_FRAMES = 2;
    localparam int PSEL_W       = 5;
    localparam int CNT_W        = 1;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              in_valid;
    logic [PSEL_W-1:0] pal_sel;
    logic [IDX_W-1:0]  index;
    logic              key_en;
    logic              wr_en;
    logic [PSEL_W-1:0] wr_pal;
    logic [IDX_W-1:0]  wr_idx;
    logic [3*CW-1:0]   wr_data;
    logic              flash_en;
    logic              frame_tick;
    logic              out_valid;
    logic [CW-1:0]     red, green, blue;
    logic              out_transp;
    flash_state_t      flash_state;
    logic [CNT_W-1:0]  flash_cnt;
    logic              flash_phase;

    int total = 0;
    int bad   = 0;

    palette_bank_lut #(
        .NUM_PAL      (NUM_PAL),
        .IDX_W        (IDX_W),
        .COLOR_W      (CW),
        .FLASH_FRAMES (FLASH_FRAMES),
        .TRANSP_IDX   (0)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .in_valid    (in_valid),
        .pal_sel     (pal_sel),
        .index       (index),
        .key_en      (key_en),
        .wr_en       (wr_en),
        .wr_pal      (wr_pal),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .flash_en    (flash_en),
        .frame_tick  (frame_tick),
        .out_valid   (out_valid),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .out_transp  (out_transp),
        .flash_state (flash_state),
        .flash_cnt   (flash_cnt),
        .flash_phase (flash_phase)
    );

    // clock / reset
    always #5 Clk = !Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, summary follows");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic step();
        @(negedge Clk);
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        key_en     = 1'b0;
        wr_en      = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic req(input logic [PSEL_W-1:0] p, input logic [IDX_W-1:0] i, input logic k);
        in_valid = 1'b1;
        pal_sel  = p;
        index    = i;
        key_en   = k;
    endtask

    task automatic wr(input logic [PSEL_W-1:0] p, input logic [IDX_W-1:0] i, input logic [3*CW-1:0] d);
        wr_en   = 1'b1;
        wr_pal  = p;
        wr_idx  = i;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // comparison helpers
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3*CW-1:0] rgb, input logic tr);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_rgb"}, 32'({red, green, blue}), 32'(rgb));
        chk({tag, "_transp"}, 32'(out_transp), 32'(tr));
    endtask

    task automatic chk_fsm(input string tag, input flash_state_t st, input logic c, input logic ph);
        chk({tag, "_state"}, 32'(flash_state), 32'(st));
        chk({tag, "_cnt"}, 32'(flash_cnt), 32'(c));
        chk({tag, "_phase"}, 32'(flash_phase), 32'(ph));
    endtask

    logic [3*CW-1:0] b2b_exp [4];

    initial begin
        Reset    = 1'b1;
        flash_en = 1'b0;
        pal_sel  = '0;
        index    = '0;
        wr_pal   = '0;
        wr_idx   = '0;
        wr_data  = '0;
        idle();
        repeat (3) step();
        chk_out("reset", 1'b0, 12'h000, 1'b0);
        chk_fsm("reset", STEADY, 1'b0, 1'b0);
        Reset = 1'b0;
        step();

        // write then read back with 2-edge latency
        wr(5'd3, 4'd5, 12'hA62);
        step();
        req(5'd3, 4'd5, 1'b0);
        step();
        idle();
        chk("lat_edge1_valid", 32'(out_valid), 32'd0);
        step();
        chk_out("basic", 1'b1, 12'hA62, 1'b0);
        step();
        chk("basic_drop_valid", 32'(out_valid), 32'd0);

        // back-to-back requests to distinct entries
        b2b_exp[0] = 12'h1F3;
        b2b_exp[1] = 12'h2E4;
        b2b_exp[2] = 12'h3D5;
        b2b_exp[3] = 12'h4C6;
        for (int i = 0; i < 4; i++) wr(5'd1, 4'(i), b2b_exp[i]);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) req(5'd1, 4'(i), 1'b0);
            else idle();
            step();
            if (i >= 1) chk_out($sformatf("b2b%0d", i - 1), 1'b1, b2b_exp[i-1], 1'b0);
        end
        step();
        chk_out("b2b_hold", 1'b0, 12'h4C6, 1'b0);

        // same-cycle write/read collision returns the new data
        wr(5'd2, 4'd7, 12'h123);
        wr_en = 1'b1; wr_pal = 5'd2; wr_idx = 4'd7; wr_data = 12'hBEE;
        req(5'd2, 4'd7, 1'b0);
        step();
        idle();
        step();
        chk_out("bypass", 1'b1, 12'hBEE, 1'b0);
        // write to a neighbouring entry must not bypass
        wr_en = 1'b1; wr_pal = 5'd2; wr_idx = 4'd6; wr_data = 12'h777;
        req(5'd2, 4'd7, 1'b0);
        step();
        idle();
        step();
        chk_out("no_bypass", 1'b1, 12'hBEE, 1'b0);

        // transparency keying
        req(5'd1, 4'd0, 1'b1);
        step();
        idle();
        step();
        chk_out("key_on", 1'b1, 12'h000, 1'b1);
        req(5'd1, 4'd0, 1'b0);
        step();
        req(5'd1, 4'd1, 1'b1);
        step();
        idle();
        chk_out("key_off", 1'b1, 12'h1F3, 1'b0);
        step();
        chk_out("key_other_idx", 1'b1, 12'h2E4, 1'b0);

        // out-of-range palette select and ignored writes
        req(5'd30, 4'd5, 1'b0);
        step();
        wr_en = 1'b1; wr_pal = 5'd31; wr_idx = 4'd5; wr_data = 12'hFFF;
        req(5'd31, 4'd5, 1'b0);
        step();
        idle();
        chk_out("oor30", 1'b1, 12'h000, 1'b0);
        step();
        chk_out("oor31_bypass", 1'b1, 12'h000, 1'b0);
        req(5'd3, 4'd5, 1'b0);
        step();
        idle();
        step();
        chk_out("after_oor_wr", 1'b1, 12'hA62, 1'b0);

        // flash effect with constant requests
        req(5'd3, 4'd5, 1'b0);
        flash_en = 1'b1;
        step();
        chk_fsm("flash_entry", FLASHING, 1'b0, 1'b0);
        step();
        chk_out("flash_pre", 1'b1, 12'hA62, 1'b0);
        tick();
        chk_fsm("tick1", FLASHING, 1'b1, 1'b0);
        tick();
        chk_fsm("tick2", FLASHING, 1'b0, 1'b1);
        chk_out("tick2_same_edge", 1'b1, 12'hA62, 1'b0);
        step();
        chk_out("tick2_white", 1'b1, 12'hFFF, 1'b0);
        req(5'd1, 4'd0, 1'b1);
        step();
        req(5'd3, 4'd5, 1'b0);
        step();
        chk_out("flash_transp", 1'b1, 12'h000, 1'b1);
        step();
        chk_out("flash_white_again", 1'b1, 12'hFFF, 1'b0);
        tick();
        tick();
        chk_fsm("tick4", FLASHING, 1'b0, 1'b0);
        step();
        chk_out("tick4_colour", 1'b1, 12'hA62, 1'b0);
        tick();
        tick();
        chk_fsm("tick6", FLASHING, 1'b0, 1'b1);
        step();
        chk_out("tick6_white", 1'b1, 12'hFFF, 1'b0);
        flash_en = 1'b0;
        tick();
        chk_fsm("clear_wins", STEADY, 1'b0, 1'b0);
        step();
        chk_out("clear_colour", 1'b1, 12'hA62, 1'b0);

        // reset with requests in flight
        req(5'd2, 4'd7, 1'b0);
        step();
        req(5'd1, 4'd3, 1'b0);
        #1;
        Reset = 1'b1;
        #1;
        chk_out("rst_async", 1'b0, 12'h000, 1'b0);
        step();
        idle();
        step();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("rst_drain%0d", i), 1'b0, 12'h000, 1'b0);
        end
        req(5'd3, 4'd5, 1'b0);
        step();
        req(5'd2, 4'd7, 1'b0);
        step();
        idle();
        chk_out("rst_keep_a", 1'b1, 12'hA62, 1'b0);
        step();
        chk_out("rst_keep_b", 1'b1, 12'hBEE, 1'b0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
